quad_step_gen: RTL and testbench

//  Quadrature transmitter: converts step commands into rotary-encoder rot_a/rot_b waveforms.

---
 rtl/quad_step_gen_pkg.sv | 24 ++
 rtl/quad_step_gen_if.sv | 24 ++
 rtl/quad_step_gen_dwell_timer.sv | 29 ++
 rtl/quad_step_gen.sv | 127 ++++++++++++
 tb/tb_quad_step_gen.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_step_gen_pkg.sv
// Shared definitions for the quadrature step generator: FSM encoding,
// per-direction phase levels and the direction encoding.
package quad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PH1,
      ST_PH2,
      ST_PH3,
      ST_PH4,
      ST_GAP
   } quad_state_e;

   localparam logic DIR_CW = 1'b1;

   // {rot_a, rot_b} for each phase; every detent ends at rest level 00
   localparam logic [1:0] QUAD_CW  [0:3] = '{2'b10, 2'b11, 2'b01, 2'b00};
   localparam logic [1:0] QUAD_CCW [0:3] = '{2'b01, 2'b11, 2'b10, 2'b00};

   function automatic logic [1:0] quad_level(input logic dir, input logic [1:0] idx);
      return (dir == DIR_CW) ? QUAD_CW[idx] : QUAD_CCW[idx];
   endfunction

endpackage

// File: rtl/quad_step_gen_if.sv
// Command handshake and quadrature output bundle of the step generator.
interface quad_step_gen_if #(
   parameter int CNT_W = 8
);
   logic             step_valid;
   logic             step_ready;
   logic             step_dir;
   logic [CNT_W-1:0] step_count;
   logic             abort;
   logic             rot_a;
   logic             rot_b;
   logic             busy;
   logic             done;

   modport master (
      output step_valid, step_dir, step_count, abort,
      input  step_ready, rot_a, rot_b, busy, done
   );

   modport slave (
      input  step_valid, step_dir, step_count, abort,
      output step_ready, rot_a, rot_b, busy, done
   );
endinterface

// File: rtl/quad_step_gen_dwell_timer.sv
// Reloadable down-counter: start loads (hold cycles - 1), expire pulses in
// the last cycle of the hold so the owner can change state on that edge.
module quad_dwell_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] load_val,
   output logic         expire
);
   logic [W-1:0] cnt;
   logic         run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         cnt <= load_val;
         run <= 1'b1;
      end else if (run) begin
         if (cnt == '0) run <= 1'b0;
         else           cnt <= cnt - 1'b1;
      end
   end

   assign expire = run && (cnt == '0);
endmodule

// File: rtl/quad_step_gen.sv
// Quadrature transmitter: turns step commands into rot_a/rot_b Gray
// waveforms, one full 4-phase cycle (ending at 00) per detent.
module quad_step_gen
   import quad_pkg::*;
#(
   parameter int PHASE_CYCLES = 4,
   parameter int GAP_CYCLES   = 0,
   parameter int CNT_W        = 8
) (
   input logic            clk,
   input logic            rst_n,
   quad_step_gen_if.slave bus
);
   localparam int DWELL_MAX = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
   localparam int TMR_W     = $clog2(DWELL_MAX + 1);
   localparam logic [TMR_W-1:0] PHASE_LOAD = TMR_W'(PHASE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   quad_state_e      state;
   logic [1:0]       ab_q;
   logic             ready_q;
   logic             done_q;
   logic             dir_q;
   logic             abort_q;
   logic [CNT_W-1:0] remaining;

   logic             accept;
   logic             last_detent;
   logic             tmr_start;
   logic [TMR_W-1:0] tmr_load;
   logic             expire;

   always_comb begin
      accept      = (state == ST_IDLE) && bus.step_valid;
      // an abort arriving in the very cycle PH4 expires still ends the command here
      last_detent = (remaining == CNT_W'(1)) || abort_q || bus.abort;
      tmr_start   = 1'b0;
      tmr_load    = PHASE_LOAD;
      unique case (state)
         ST_IDLE: tmr_start = accept && (bus.step_count != '0);
         ST_PH1, ST_PH2, ST_PH3, ST_GAP: tmr_start = expire;
         ST_PH4: begin
            tmr_start = expire && !last_detent;
            if (GAP_CYCLES > 0) tmr_load = GAP_LOAD;
         end
         default: tmr_start = 1'b0;
      endcase
   end

   quad_dwell_timer #(.W(TMR_W)) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (tmr_start),
      .load_val (tmr_load),
      .expire   (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ab_q      <= 2'b00;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         dir_q     <= DIR_CW;
         abort_q   <= 1'b0;
         remaining <= '0;
      end else begin
         done_q <= 1'b0;
         if (state != ST_IDLE) abort_q <= abort_q | bus.abort;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  dir_q     <= bus.step_dir;
                  abort_q   <= bus.abort;
                  remaining <= bus.step_count;
                  if (bus.step_count == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state   <= ST_PH1;
                     ab_q    <= quad_level(bus.step_dir, 2'd0);
                     ready_q <= 1'b0;
                  end
               end
            end
            ST_PH1: if (expire) begin
               state <= ST_PH2;
               ab_q  <= quad_level(dir_q, 2'd1);
            end
            ST_PH2: if (expire) begin
               state <= ST_PH3;
               ab_q  <= quad_level(dir_q, 2'd2);
            end
            ST_PH3: if (expire) begin
               state <= ST_PH4;
               ab_q  <= quad_level(dir_q, 2'd3);
            end
            ST_PH4: if (expire) begin
               if (last_detent) begin
                  state     <= ST_IDLE;
                  ready_q   <= 1'b1;
                  done_q    <= 1'b1;
                  remaining <= '0;
               end else begin
                  remaining <= remaining - 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state <= ST_GAP;
                  end else begin
                     state <= ST_PH1;
                     ab_q  <= quad_level(dir_q, 2'd0);
                  end
               end
            end
            ST_GAP: if (expire) begin
               state <= ST_PH1;
               ab_q  <= quad_level(dir_q, 2'd0);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rot_a      = ab_q[1];
   assign bus.rot_b      = ab_q[0];
   assign bus.step_ready = ready_q;
   assign bus.busy       = ~ready_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_quad_step_gen.sv
// Scoreboard bench for quad_step_gen: two instances (PHASE=4/GAP=0 and
// PHASE=2/GAP=3) driven by directed and random commands.
module tb_quad_step_gen;
   localparam int CNT_W = 8;
   localparam int P_A = 4, G_A = 0;
   localparam int P_B = 2, G_B = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mon_en = 1'b0;
   always #5 clk = ~clk;

   quad_step_gen_if #(.CNT_W(CNT_W)) bus_a ();
   quad_step_gen_if #(.CNT_W(CNT_W)) bus_b ();

   quad_step_gen #(.PHASE_CYCLES(P_A), .GAP_CYCLES(G_A), .CNT_W(CNT_W)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   quad_step_gen #(.PHASE_CYCLES(P_B), .GAP_CYCLES(G_B), .CNT_W(CNT_W)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   typedef struct {
      logic [1:0] ab;
      logic       busy;
      logic       done;
      int         ndet;
      logic       dir;
   } samp_t;

   samp_t qa[$];
   samp_t qb[$];

   int checks = 0;
   int errors = 0;
   int det_cw[2]  = '{0, 0};
   int det_ccw[2] = '{0, 0};
   int exp_cw[2]  = '{0, 0};
   int exp_ccw[2] = '{0, 0};
   logic [1:0] prev_ab[2] = '{2'b00, 2'b00};
   logic [7:0] hist[2]    = '{8'h00, 8'h00};

   function automatic logic [1:0] lvl(input logic dir, input int ph);
      logic [1:0] cw  [4];
      logic [1:0] ccw [4];
      cw  = '{2'b10, 2'b11, 2'b01, 2'b00};
      ccw = '{2'b01, 2'b11, 2'b10, 2'b00};
      return dir ? cw[ph] : ccw[ph];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected per-sample trace of one command, from the phase table and dwell rules
   task automatic push_cmd(input int d, input logic dir, input int n);
      int p;
      int g;
      samp_t s;
      p = (d == 0) ? P_A : P_B;
      g = (d == 0) ? G_A : G_B;
      s = '{ab: 2'b00, busy: 1'b1, done: 1'b0, ndet: 0, dir: dir};
      for (int k = 0; k < n; k++) begin
         if (k > 0) begin
            for (int c = 0; c < g; c++) begin
               s.ab = 2'b00;
               if (d == 0) qa.push_back(s); else qb.push_back(s);
            end
         end
         for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < p; c++) begin
               s.ab = lvl(dir, ph);
               if (d == 0) qa.push_back(s); else qb.push_back(s);
            end
         end
      end
      s = '{ab: 2'b00, busy: 1'b0, done: 1'b1, ndet: n, dir: dir};
      if (d == 0) qa.push_back(s); else qb.push_back(s);
   endtask

   task automatic check_dut(input int d, input logic a, input logic b,
                            input logic rdy, input logic bsy, input logic dn);
      samp_t e;
      logic [1:0] ab;
      string tag;
      tag = (d == 0) ? "A" : "B";
      ab = {a, b};
      if (ab != prev_ab[d]) begin
         checks++;
         if ($countones(ab ^ prev_ab[d]) > 1) begin
            errors++;
            $display("FAIL %s_gray: ab went %b -> %b at t=%0t", tag, prev_ab[d], ab, $time);
         end
         hist[d] = {hist[d][5:0], ab};
         if (hist[d] == 8'b10_11_01_00) det_cw[d]++;
         else if (hist[d] == 8'b01_11_10_00) det_ccw[d]++;
      end
      prev_ab[d] = ab;
      e = '{ab: 2'b00, busy: 1'b0, done: 1'b0, ndet: 0, dir: 1'b0};
      if (d == 0 && qa.size() > 0) e = qa.pop_front();
      else if (d == 1 && qb.size() > 0) e = qb.pop_front();
      chk({tag, "_ab"},    int'(ab),  int'(e.ab));
      chk({tag, "_busy"},  int'(bsy), int'(e.busy));
      chk({tag, "_ready"}, int'(rdy), int'(!e.busy));
      chk({tag, "_done"},  int'(dn),  int'(e.done));
      if (e.done) begin
         if (e.dir) exp_cw[d] += e.ndet;
         else       exp_ccw[d] += e.ndet;
         chk({tag, "_detents_cw"},  det_cw[d],  exp_cw[d]);
         chk({tag, "_detents_ccw"}, det_ccw[d], exp_ccw[d]);
      end
   endtask

   task automatic set_cmd(input int d, input logic v, input logic dir,
                          input logic [CNT_W-1:0] n, input logic ab);
      if (d == 0) begin
         bus_a.step_valid = v; bus_a.step_dir = dir; bus_a.step_count = n; bus_a.abort = ab;
      end else begin
         bus_b.step_valid = v; bus_b.step_dir = dir; bus_b.step_count = n; bus_b.abort = ab;
      end
   endtask

   function automatic logic get_ready(input int d);
      return (d == 0) ? bus_a.step_ready : bus_b.step_ready;
   endfunction

   // n_eff: detents expected to be emitted (differs from n when aborted)
   task automatic issue(input int d, input logic dir, input int n, input int n_eff,
                        input logic abort_with);
      int waited;
      waited = 0;
      @(negedge clk);
      set_cmd(d, 1'b1, dir, CNT_W'(n), abort_with);
      while (get_ready(d) !== 1'b1 && waited < 6000) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 6000) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: dut %0d never ready after %0d cycles", d, waited);
         set_cmd(d, 1'b0, 1'b0, '0, 1'b0);
         return;
      end
      @(posedge clk);
      push_cmd(d, dir, n_eff);
      #1;
      // garbage on dir/count while busy must be ignored
      set_cmd(d, 1'b0, 1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 255)), 1'b0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((qa.size() > 0 || qb.size() > 0) && n < 8000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 8000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d/%0d samples outstanding", qa.size(), qb.size());
      end
   endtask

   task automatic check_reset_vals();
      chk("A_rst_ab",    int'({bus_a.rot_a, bus_a.rot_b}), 0);
      chk("A_rst_ready", int'(bus_a.step_ready), 1);
      chk("A_rst_busy",  int'(bus_a.busy), 0);
      chk("A_rst_done",  int'(bus_a.done), 0);
      chk("B_rst_ab",    int'({bus_b.rot_a, bus_b.rot_b}), 0);
      chk("B_rst_ready", int'(bus_b.step_ready), 1);
      chk("B_rst_busy",  int'(bus_b.busy), 0);
      chk("B_rst_done",  int'(bus_b.done), 0);
   endtask

   initial begin
      set_cmd(0, 1'b0, 1'b0, '0, 1'b0);
      set_cmd(1, 1'b0, 1'b0, '0, 1'b0);

      fork
         forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
               check_dut(0, bus_a.rot_a, bus_a.rot_b, bus_a.step_ready, bus_a.busy, bus_a.done);
               check_dut(1, bus_b.rot_a, bus_b.rot_b, bus_b.step_ready, bus_b.busy, bus_b.done);
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check_reset_vals();
      #2 rst_n = 1'b1;
      mon_en = 1'b1;

      // single CW detent, then CCW x3 with gaps, then zero-count commands
      issue(0, 1'b1, 1, 1, 1'b0);
      issue(1, 1'b0, 3, 3, 1'b0);
      wait_idle();
      issue(0, 1'b1, 0, 0, 1'b0);
      issue(1, 1'b0, 0, 0, 1'b0);
      wait_idle();

      // abort while idle is ignored
      @(negedge clk);
      bus_a.abort = 1'b1;
      @(negedge clk);
      bus_a.abort = 1'b0;
      issue(0, 1'b0, 2, 2, 1'b0);
      wait_idle();

      // abort together with accept stops after the first detent
      issue(1, 1'b1, 4, 1, 1'b1);
      wait_idle();

      // abort mid-PH2 of detent 2, then a command queued behind it
      issue(0, 1'b1, 10, 2, 1'b0);
      repeat (4 * P_A + P_A + 2) @(negedge clk);
      bus_a.abort = 1'b1;
      @(negedge clk);
      bus_a.abort = 1'b0;
      issue(0, 1'b0, 1, 1, 1'b0);
      wait_idle();

      // full count range
      issue(1, 1'b1, 255, 255, 1'b0);
      wait_idle();

      // asynchronous reset during PH3 of detent 1
      issue(0, 1'b1, 5, 5, 1'b0);
      repeat (2 * P_A + 2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals();
      qa.delete();
      qb.delete();
      prev_ab = '{2'b00, 2'b00};
      hist    = '{8'h00, 8'h00};
      @(negedge clk);
      #2 rst_n = 1'b1;
      issue(0, 1'b1, 1, 1, 1'b0);
      wait_idle();

      // random back-to-back commands on both instances concurrently
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               int n0;
               n0 = int'($urandom_range(0, 4));
               issue(0, 1'($urandom_range(0, 1)), n0, n0, 1'b0);
            end
         end
         begin
            for (int j = 0; j < 10; j++) begin
               int n1;
               n1 = int'($urandom_range(0, 4));
               issue(1, 1'($urandom_range(0, 1)), n1, n1, 1'b0);
            end
         end
      join
      wait_idle();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
